// File: rtl/img_sram_loader.sv
// img_sram_loader: raster pixel stream scattered into nine 3x3-interleaved activation SRAM banks
module img_sram_loader #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load_start,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  output logic [8:0]            sram_write_enable_a,
  output logic [3:0]            sram_bytemask_a,
  output logic [ADDR_WIDTH-1:0] sram_waddr_a,
  output logic [31:0]           sram_wdata_a,
  output logic                  load_busy,
  output logic                  load_done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int STRIDE = (IMG_W + 11) / 12;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t st, nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic acc, x_end, last;
  logic [1:0] lane;
  logic [3:0] bank;
  logic [ADDR_WIDTH-1:0] addr;
  always_comb begin
    acc = pixel_ready && pixel_valid;
    x_end = x == XW'(IMG_W - 1);
    last = acc && x_end && y == YW'(IMG_H - 1);
    lane = x[1:0];
    bank = 4'(3 * (int'(y) % 3) + (int'(x) / 4) % 3);
    addr = ADDR_WIDTH'((int'(y) / 3) * STRIDE + int'(x) / 12);
    nxt = st == IDLE  ? (load_start ? LOAD : IDLE) :
          st == LOAD  ? (last ? FLUSH : LOAD) :
          st == FLUSH ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      st <= IDLE;
      x <= '0;
      y <= '0;
      pixel_ready <= 1'b0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      sram_write_enable_a <= 9'h1FF;
      sram_bytemask_a <= 4'hF;
      sram_waddr_a <= '0;
      sram_wdata_a <= '0;
    end else begin
      st <= nxt;
      pixel_ready <= nxt == LOAD;
      load_busy <= nxt == LOAD || nxt == FLUSH;
      load_done <= nxt == DONE;
      sram_write_enable_a <= acc ? ~(9'd1 << bank) : 9'h1FF;
      if (acc) begin
        sram_bytemask_a <= ~(4'b1000 >> lane);
        sram_waddr_a <= addr;
        sram_wdata_a <= 32'({4{pixel_data}});
      end
      if (st == IDLE && load_start) begin
        x <= '0;
        y <= '0;
      end else if (acc) begin
        x <= x_end ? '0 : x + 1'b1;
        y <= x_end ? y + 1'b1 : y;
      end
    end
  end
endmodule

// File: tb/tb_img_sram_loader.sv
// tb_img_sram_loader: scoreboard bench for the activation SRAM loader
module tb_img_sram_loader;
  localparam int STRIDE = 3;
  typedef struct packed {
    logic [8:0]  we;
    logic [9:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;
  logic clk, arst, load_start, pixel_valid, pixel_ready, load_busy, load_done;
  logic [7:0] pixel_data;
  logic [8:0] sram_write_enable_a;
  logic [3:0] sram_bytemask_a;
  logic [9:0] sram_waddr_a;
  logic [31:0] sram_wdata_a;
  wr_t sb[$];
  logic [31:0] mem [9][128];
  int total = 0, bad = 0, mx = 0, my = 0, n_acc = 0, done_cnt = 0, done0 = 0;
  bit acc_q = 0, mon_en = 0;
  img_sram_loader dut (
    .clk(clk), .arst(arst), .load_start(load_start), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_data(pixel_data),
    .sram_write_enable_a(sram_write_enable_a), .sram_bytemask_a(sram_bytemask_a),
    .sram_waddr_a(sram_waddr_a), .sram_wdata_a(sram_wdata_a),
    .load_busy(load_busy), .load_done(load_done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_q) begin
        wr_t e;
        e = sb.pop_front();
        total++;
        if ({sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a} !== e) begin
          bad++;
          $display("FAIL write: got we=%h addr=%0d mask=%b data=%h, expected we=%h addr=%0d mask=%b data=%h",
                   sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a, e.we, e.addr, e.mask, e.data);
        end
        for (int k = 0; k < 9; k++)
          if (sram_write_enable_a[k] === 1'b0 && sram_waddr_a < 10'd128)
            for (int b = 0; b < 4; b++)
              if (sram_bytemask_a[b] === 1'b0) mem[k][sram_waddr_a[6:0]][8*b+:8] = sram_wdata_a[8*b+:8];
      end else if (sram_write_enable_a !== 9'h1FF) begin
        total++;
        bad++;
        $display("FAIL stray_strobe: got we=%h, expected 1ff (no acceptance last cycle)", sram_write_enable_a);
      end
      if (load_done === 1'b1) done_cnt++;
    end
  end
  task automatic drive(input logic v, input logic [7:0] d, input logic s);
    wr_t e;
    @(negedge clk);
    pixel_valid = v;
    pixel_data = d;
    load_start = s;
    #1;
    acc_q = v && pixel_ready === 1'b1;
    if (acc_q) begin
      e.we = ~(9'd1 << (3 * (my % 3) + (mx / 4) % 3));
      e.addr = 10'((my / 3) * STRIDE + (mx / 4) / 3);
      e.mask = ~(4'b1000 >> (mx % 4));
      e.data = {4{d}};
      sb.push_back(e);
      n_acc++;
      if (mx == 31) begin
        mx = 0;
        my++;
      end else mx++;
    end
  endtask
  task automatic start_frame();
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 128; j++) mem[i][j] = 'x;
    mx = 0;
    my = 0;
    n_acc = 0;
    done0 = done_cnt;
    drive(0, 8'h00, 1);
  endtask
  task automatic run_pixels(input int target, input int gap, input int start_at, output bit to);
    int b;
    bit v;
    b = 0;
    to = 0;
    while (n_acc < target) begin
      if (b++ > 5000) begin
        to = 1;
        break;
      end
      v = $urandom_range(99) >= gap;
      drive(v, v ? 8'(mx + my) : 8'($urandom), v && n_acc == start_at);
    end
  endtask
  function automatic int readback();
    int errs, bk, ad, ln;
    logic [31:0] w;
    errs = 0;
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 32; xx++) begin
        bk = 3 * (yy % 3) + (xx / 4) % 3;
        ad = (yy / 3) * STRIDE + (xx / 4) / 3;
        ln = xx % 4;
        w = mem[bk][ad];
        if (w[8*(3-ln)+:8] !== 8'(xx + yy)) errs++;
      end
    return errs;
  endfunction
  task automatic test_reset();
    arst = 1;
    load_start = 0;
    pixel_valid = 0;
    pixel_data = 0;
    drive(1, 8'h77, 0);
    total++;
    if ({sram_write_enable_a, sram_bytemask_a, sram_waddr_a, sram_wdata_a, pixel_ready, load_busy, load_done}
        !== {9'h1FF, 4'hF, 10'd0, 32'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_values: got we=%h mask=%b addr=%0d data=%h rdy=%b busy=%b done=%b",
               sram_write_enable_a, sram_bytemask_a, sram_waddr_a, sram_wdata_a, pixel_ready, load_busy, load_done);
    end
    #2 arst = 0;
    mon_en = 1;
    drive(1, 8'h77, 0);
    drive(1, 8'h77, 0);
    total++;
    if ({pixel_ready, load_busy} !== 2'b00) begin
      bad++;
      $display("FAIL idle_ignores_valid: got rdy=%b busy=%b, expected 0 0", pixel_ready, load_busy);
    end
  endtask
  task automatic test_first_pixel();
    start_frame();
    drive(1, 8'h11, 0);
    drive(0, 8'h00, 0);
    total++;
    if ({sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a} !== {9'h1FE, 10'd0, 4'b0111, 32'h11111111}) begin
      bad++;
      $display("FAIL first_pixel: got we=%h addr=%0d mask=%b data=%h, expected 1fe 0 0111 11111111",
               sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a);
    end
    total++;
    if (load_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_load: got %b expected 1", load_busy);
    end
  endtask
  task automatic test_pixel_5_4();
    bit to;
    run_pixels(133, 0, -1, to);
    drive(1, 8'hA5, 0);
    drive(0, 8'h00, 0);
    total++;
    if (to || {sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a} !== {9'h1EF, 10'd3, 4'b1011, 32'hA5A5A5A5}) begin
      bad++;
      $display("FAIL pixel_5_4: got we=%h addr=%0d mask=%b data=%h timeout=%0d, expected 1ef 3 1011 a5a5a5a5",
               sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a, to);
    end
  endtask
  task automatic test_frame_end();
    bit to;
    run_pixels(1024, 30, -1, to);
    drive(1, 8'h55, 0);
    total++;
    if (to || {sram_write_enable_a, sram_waddr_a, sram_bytemask_a, pixel_ready, load_done} !== {9'h1EF, 10'd32, 4'b1110, 2'b00}) begin
      bad++;
      $display("FAIL last_pixel: got we=%h addr=%0d mask=%b rdy=%b done=%b timeout=%0d, expected 1ef 32 1110 0 0",
               sram_write_enable_a, sram_waddr_a, sram_bytemask_a, pixel_ready, load_done, to);
    end
    drive(1, 8'h55, 0);
    total++;
    if ({load_done, pixel_ready, load_busy} !== 3'b100) begin
      bad++;
      $display("FAIL done_pulse: got done=%b rdy=%b busy=%b, expected 1 0 0", load_done, pixel_ready, load_busy);
    end
    drive(1, 8'h55, 0);
    total++;
    if (load_done !== 1'b0 || done_cnt - done0 !== 1 || n_acc !== 1024) begin
      bad++;
      $display("FAIL done_once: got done=%b pulses=%0d accepted=%0d, expected 0 1 1024", load_done, done_cnt - done0, n_acc);
    end
  endtask
  task automatic test_full_frame(input string name, input int gap, input int start_at);
    bit to;
    int errs;
    start_frame();
    run_pixels(1024, gap, start_at, to);
    for (int i = 0; i < 4; i++) drive(1, 8'hCC, 0);
    errs = readback();
    total++;
    if (to || errs !== 0) begin
      bad++;
      $display("FAIL %s_readback: got %0d wrong bytes timeout=%0d, expected 0", name, errs, to);
    end
    total++;
    if (done_cnt - done0 !== 1 || n_acc !== 1024 || pixel_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_frame: got pulses=%0d accepted=%0d rdy=%b, expected 1 1024 0", name, done_cnt - done0, n_acc, pixel_ready);
    end
  endtask
  task automatic test_reset_midframe();
    bit to;
    start_frame();
    run_pixels(500, 0, -1, to);
    drive(0, 8'h00, 0);
    #2 arst = 1;
    #1;
    total++;
    if (to || {sram_write_enable_a, sram_bytemask_a, sram_waddr_a, sram_wdata_a, pixel_ready, load_busy, load_done}
        !== {9'h1FF, 4'hF, 10'd0, 32'd0, 3'b000}) begin
      bad++;
      $display("FAIL async_reset: got we=%h mask=%b addr=%0d data=%h rdy=%b busy=%b done=%b",
               sram_write_enable_a, sram_bytemask_a, sram_waddr_a, sram_wdata_a, pixel_ready, load_busy, load_done);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hEE, 0);
      total++;
      if ({sram_write_enable_a, pixel_ready, load_busy} !== {9'h1FF, 2'b00}) begin
        bad++;
        $display("FAIL held_reset: got we=%h rdy=%b busy=%b, expected 1ff 0 0", sram_write_enable_a, pixel_ready, load_busy);
      end
    end
    #2 arst = 0;
    drive(1, 8'hEE, 0);
    drive(0, 8'h00, 0);
    start_frame();
    drive(1, 8'h3C, 0);
    drive(0, 8'h00, 0);
    total++;
    if ({sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a} !== {9'h1FE, 10'd0, 4'b0111, 32'h3C3C3C3C}) begin
      bad++;
      $display("FAIL restart_origin: got we=%h addr=%0d mask=%b data=%h, expected 1fe 0 0111 3c3c3c3c",
               sram_write_enable_a, sram_waddr_a, sram_bytemask_a, sram_wdata_a);
    end
  endtask
  initial begin
    test_reset();
    test_first_pixel();
    test_pixel_5_4();
    test_frame_end();
    test_full_frame("full", 0, -1);
    test_full_frame("gaps", 50, -1);
    test_full_frame("restart_in_load", 0, 100);
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/img_sram_loader.md
Name: img_sram_loader

Overview:
- Writer end of the activation-SRAM interface that conv_top reads from.
- Accepts a raster-order 8-bit pixel stream over a valid/ready handshake.
- Scatters pixels into the nine 128x32b input banks a0..a8 using the 3x3 bank interleave conv_top's read side expects, through bank write-enable, bytemask, waddr and wdata.
- Signals load_done so the controller can pulse conv_start.

Parameters:
- IMG_W, 32: image width in pixels; must be a multiple of 4.
- IMG_H, 32: image height in pixels.
- DATA_WIDTH, 8: pixel width.
- ADDR_WIDTH, 10: SRAM address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst  input  1  reset; asynchronous, active-high.
- load_start  input  1  one-cycle pulse; starts a frame load; sampled only in IDLE.
- pixel_valid  input  1  pixel_data is valid this cycle.
- pixel_ready  output  1  loader accepts a pixel this cycle.
- pixel_data  input  DATA_WIDTH  pixel, raster order, x fastest.
- sram_write_enable_a  output  9  active-low write enable; bit k drives bank ak.
- sram_bytemask_a  output  4  active-low lane mask; bit 3 = byte [31:24].
- sram_waddr_a  output  ADDR_WIDTH  write address, shared by all banks.
- sram_wdata_a  output  32  pixel replicated into all 4 lanes.
- load_busy  output  1  high in LOAD and FLUSH.
- load_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs registered. sram_write_enable_a=9'h1FF, sram_bytemask_a=4'hF, sram_waddr_a=0, sram_wdata_a=0, pixel_ready=0, load_busy=0, load_done=0. FSM=IDLE, x=y=0.
- Reset asserted mid-frame aborts immediately to the reset state. No partial-write strobe may follow.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: pixel_ready=0; pixel_valid ignored. load_start -> LOAD, x=y=0.
  - LOAD: pixel_ready=1. A pixel is accepted on pixel_valid&&pixel_ready. Acceptance of pixel (IMG_W-1, IMG_H-1) -> FLUSH.
  - FLUSH: pixel_ready=0; the last write strobe is driven; -> DONE.
  - DONE: load_done=1 for exactly this cycle; -> IDLE.
- load_start is ignored in LOAD, FLUSH and DONE.
- Counters: x increments per accepted pixel. At IMG_W-1, x wraps to 0 and y increments. No pixel beyond the frame is ever accepted.
- Mapping for accepted pixel (x,y):
  - wc = x/4; lane = x%4.
  - bank = 3*(y%3) + (wc%3).
  - waddr = (y/3)*ceil(IMG_W/12) + wc/3. For 32x32 the stride is 3 and the maximum address is 32.
  - bytemask = all ones except bit (3-lane) = 0. Lane 0 is byte [31:24].
  - wdata = {4{pixel}}.
- Latency: the write strobe appears exactly 1 cycle after acceptance and lasts 1 cycle, with exactly one sram_write_enable_a bit low. No acceptance in a cycle means all write enables are 1 in the next cycle. waddr, bytemask and wdata may hold stale values when no bit is low.
- Throughput: 1 pixel/cycle sustained. A 32x32 frame takes 1024 write cycles.
- load_done occurs 2 cycles after the last acceptance, i.e. 1 cycle after the last write strobe.
- Stalls: pixel_valid low in LOAD holds x/y with no write. There is no timeout.

Test Plan:
- Reset, load_start, first pixel 0x11 at (0,0) -> next cycle sram_write_enable_a=9'h1FE, waddr=0, bytemask=4'b0111, wdata=32'h11111111.
- Pixel 0xA5 at (5,4) -> bank a4 (enable 9'h1EF), waddr=3, bytemask=4'b1011, wdata=32'hA5A5A5A5.
- Full 1024-pixel frame with pixel=(x+y)&0xFF, valid always high -> back-read of all 9 banks matches the golden 3x3 interleave. Last pixel (31,31) goes to bank a4, waddr=32, bytemask=4'b1110. load_done is high exactly once, 2 cycles after the last acceptance. pixel_ready is low from FLUSH onward.
- Random pixel_valid gaps (50%) -> same bank contents as the gap-free run. No write strobe in any cycle following a non-accepting cycle. Frame length = 1024 acceptances.
- load_start pulsed during LOAD at pixel 100 -> counters not reset; frame completes normally with a single load_done.
- arst asserted after pixel 500, released, new load_start -> all outputs at reset values during reset; no write strobe after reset. The new frame restarts at (0,0) -> bank a0, waddr 0.
